// File: rtl/srt_divisor_shift_reg.sv
// Divisor (M) register for the SRT radix-2 divider: per-bit 4:1 mux + D flop,
// supporting hold, parallel load and logical left shift, with true/inverted outputs.

module SrtMux4 (
  input  logic [3:0] i,
  input  logic [1:0] sel,
  output logic       o
);
  assign o = i[sel];
endmodule

module SrtDff (
  input  logic clk,
  input  logic d,
  output logic q,
  output logic not_q
);
  logic state_q;

  always_ff @(posedge clk) begin
    state_q <= d;
  end

  assign q     = state_q;
  assign not_q = ~state_q;
endmodule

module srt_divisor_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] m,
  input  logic             lshift,
  input  logic             left_shift_entry_wire,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] not_q
);
  logic [WIDTH-1:0] shiftSrc;
  logic [WIDTH-1:0] muxOut;
  logic [WIDTH-1:0] reg_d;
  logic [1:0]       sel;

  assign sel      = {lshift, load};
  assign shiftSrc = {q[WIDTH-2:0], left_shift_entry_wire};

  // Reset gates the D input, so it overrides whatever the mux selected.
  assign reg_d = rst_n ? muxOut : '0;

  for (genvar g = 0; g < WIDTH; g++) begin : gBit
    SrtMux4 uMux (
      .i   ({shiftSrc[g], shiftSrc[g], m[g], q[g]}),
      .sel (sel),
      .o   (muxOut[g])
    );

    SrtDff uDff (
      .clk   (clk),
      .d     (reg_d[g]),
      .q     (q[g]),
      .not_q (not_q[g])
    );
  end
endmodule

// File: tb/tb_srt_divisor_shift_reg.sv
// Self-checking bench for srt_divisor_shift_reg: directed scenarios plus
// randomized traffic compared against an arithmetic reference model.

module tb_srt_divisor_shift_reg;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             load;
  logic [WIDTH-1:0] m;
  logic             lshift;
  logic             entry;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] not_q;

  int errors = 0;
  int checks = 0;
  int model  = 0;

  srt_divisor_shift_reg #(.WIDTH(WIDTH)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .load                  (load),
    .m                     (m),
    .lshift                (lshift),
    .left_shift_entry_wire (entry),
    .q                     (q),
    .not_q                 (not_q)
  );

  always #5 clk = ~clk;

  // Reference behaviour from the register's rules, using integer arithmetic.
  task automatic modelEdge();
    if (!rst_n)      model = 0;
    else if (lshift) model = (model * 2 + int'(entry)) % 256;
    else if (load)   model = int'(m);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    modelEdge();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; load = 1'b1; m = 8'hFF; lshift = 1'b0; entry = 1'b0;
    tick();
    checks++;
    if (q !== 8'h00) begin
      errors++; $display("[TB] FAIL reset_q: got %h expected 00", q);
    end
    checks++;
    if (not_q !== 8'hFF) begin
      errors++; $display("[TB] FAIL reset_not_q: got %h expected FF", not_q);
    end
  endtask

  task automatic test_load();
    rst_n = 1'b1; load = 1'b1; m = 8'h17;
    tick();
    checks++;
    if (q !== 8'h17) begin
      errors++; $display("[TB] FAIL load17_q: got %h expected 17", q);
    end
    checks++;
    if (not_q !== 8'hE8) begin
      errors++; $display("[TB] FAIL load17_not_q: got %h expected E8", not_q);
    end
    m = 8'h6A;
    tick();
    checks++;
    if (q !== 8'h6A) begin
      errors++; $display("[TB] FAIL load6A_q: got %h expected 6A", q);
    end
  endtask

  task automatic test_hold();
    load = 1'b0; lshift = 1'b0;
    for (int k = 0; k < 3; k++) begin
      m = WIDTH'($urandom);
      tick();
      checks++;
      if (q !== 8'h6A) begin
        errors++; $display("[TB] FAIL hold_%0d: got %h expected 6A", k, q);
      end
    end
  endtask

  task automatic test_shift_entry();
    logic [7:0] exp [4];
    exp = '{8'hD5, 8'hAB, 8'h57, 8'hAF};
    lshift = 1'b1; entry = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (q !== exp[k]) begin
        errors++; $display("[TB] FAIL shift1_%0d: got %h expected %h", k, q, exp[k]);
      end
    end
    lshift = 1'b0; entry = 1'b0;
    tick();
    checks++;
    if (q !== 8'hAF) begin
      errors++; $display("[TB] FAIL shift_hold: got %h expected AF", q);
    end
  endtask

  task automatic test_priority();
    load = 1'b1; m = 8'h81;
    tick();
    lshift = 1'b1; m = 8'h00; entry = 1'b0;
    tick();
    checks++;
    if (q !== 8'h02) begin
      errors++; $display("[TB] FAIL shift_beats_load: got %h expected 02", q);
    end
    load = 1'b0; lshift = 1'b0;
  endtask

  task automatic test_shift_out_and_reset();
    load = 1'b1; m = 8'hAF;
    tick();
    load = 1'b0; lshift = 1'b1; entry = 1'b0;
    for (int k = 0; k < WIDTH; k++) begin
      tick();
      checks++;
      if (q !== WIDTH'(model)) begin
        errors++; $display("[TB] FAIL shiftout_%0d: got %h expected %h", k, q, WIDTH'(model));
      end
    end
    checks++;
    if (q !== 8'h00) begin
      errors++; $display("[TB] FAIL shiftout_final: got %h expected 00", q);
    end
    lshift = 1'b0; load = 1'b1; m = 8'hC3;
    tick();
    load = 1'b0; lshift = 1'b1; entry = 1'b1;
    tick();
    rst_n = 1'b0;
    tick();
    checks++;
    if (q !== 8'h00 || not_q !== 8'hFF) begin
      errors++; $display("[TB] FAIL reset_mid_shift: got q=%h not_q=%h expected 00/FF", q, not_q);
    end
    rst_n = 1'b1; lshift = 1'b0; entry = 1'b0;
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      rst_n  = ($urandom_range(0, 19) != 0);
      load   = 1'($urandom);
      lshift = 1'($urandom);
      entry  = 1'($urandom);
      m      = WIDTH'($urandom);
      tick();
      checks++;
      if (q !== WIDTH'(model) || not_q !== WIDTH'(255 - model)) begin
        errors++;
        $display("[TB] FAIL random_%0d: got q=%h not_q=%h expected %h/%h",
                 k, q, not_q, WIDTH'(model), WIDTH'(255 - model));
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; load = 1'b0; m = '0; lshift = 1'b0; entry = 1'b0;
    test_reset();
    test_load();
    test_hold();
    test_shift_entry();
    test_priority();
    test_shift_out_and_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
